pwm_sample_feeder: RTL

- Upstream stage of the DDR PWM output.
- Accepts signed two's-complement audio samples from the synth/mixer on a valid/ready stream and buffers them in a small FIFO.
- On each PWM `next_val` request it pops one sample, rounds and saturates it to NBITS, and converts it to offset binary.
- Presents the result as a registered, stable `data_out` that drives the PWM `data_in`.
- Handles start-up priming and underrun without producing output steps.

---
 rtl/audio_pkg.sv | 36 +++
 rtl/pwm_sample_feeder_fifo.sv | 56 +++++
 rtl/pwm_sample_feeder.sv | 87 ++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: midscale constant, stream state and the
// signed-to-offset-binary rounding/saturating converter.
package audio_pkg;

  localparam int PWM_NBITS = 12;
  localparam logic [PWM_NBITS-1:0] MIDSCALE = 12'h800;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } feed_state_t;

  // x is the sign-extended in_bits sample; the result holds nbits offset-binary bits in its LSBs.
  function automatic logic [31:0] s2ob_round_sat(input logic signed [31:0] x,
                                                 input int in_bits,
                                                 input int nbits);
    logic signed [31:0] rnd;
    logic signed [31:0] smax;
    logic signed [31:0] sum;
    logic signed [31:0] shr;
    logic [31:0] mask;
    rnd  = 32'sd1 <<< (in_bits - nbits - 1);
    smax = (32'sd1 <<< (in_bits - 1)) - 32'sd1;
    sum  = x + rnd;
    if (sum > smax) begin
      sum = smax;
    end else begin
      sum = x + rnd;
    end
    shr  = sum >>> (in_bits - nbits);
    mask = (32'd1 << nbits) - 32'd1;
    // Adding half-range modulo 2^nbits flips the MSB into offset binary.
    return (32'(shr) + (32'd1 << (nbits - 1))) & mask;
  endfunction

endpackage

// File: rtl/pwm_sample_feeder_fifo.sv
// First-word-fall-through synchronous FIFO with a separate occupancy counter.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // Storage array, written on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pwm_sample_feeder.sv
// Buffers signed audio samples and hands one converted offset-binary value
// to the PWM per next_val request, with priming and underrun accounting.
module pwm_sample_feeder
  import audio_pkg::*;
#(
  parameter int IN_BITS   = 16,
  parameter int NBITS     = 12,
  parameter int DEPTH     = 16,
  parameter int PRIME_LVL = DEPTH / 2,
  parameter int STAT_BITS = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [IN_BITS-1:0]       s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     next_val,
  output logic [NBITS-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     underrun,
  output logic [STAT_BITS-1:0]     underrun_cnt,
  input  logic                     clr_stats
);

  localparam int FW = $clog2(DEPTH) + 1;
  localparam logic [NBITS-1:0] MID = {1'b1, {(NBITS-1){1'b0}}};

  feed_state_t        state;
  logic               full;
  logic               empty;
  logic               pop;
  logic               starve;
  logic [IN_BITS-1:0] head;
  logic [NBITS-1:0]   conv;

  assign s_ready = ~full;
  assign pop     = next_val & (state == RUN) & ~empty;
  assign starve  = next_val & (state == RUN) & empty;
  assign conv    = NBITS'(s2ob_round_sat(32'(signed'(head)), IN_BITS, NBITS));

  sync_fifo #(
    .WIDTH (IN_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (s_valid),
    .pop   (pop),
    .wdata (s_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fill_level)
  );

  // Priming/run FSM, output register and underrun statistics
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= PRIME;
      data_out     <= MID;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= 1'b0;
      case (state)
        PRIME: begin
          if (fill_level >= FW'(PRIME_LVL)) state <= RUN;
        end
        RUN: begin
          if (pop) begin
            data_out <= conv;
          end else if (starve) begin
            underrun <= 1'b1;
            state    <= PRIME;
          end
        end
        default: state <= PRIME;
      endcase
      if (clr_stats) begin
        underrun_cnt <= '0;
      end else if (starve && (underrun_cnt != '1)) begin
        underrun_cnt <= underrun_cnt + STAT_BITS'(1);
      end
    end
  end

endmodule
